wb_stage: RTL and testbench

Writeback stage of the 32-bit RISC-V pipeline. It selects the register-file write data from three sources: ALU result, memory load data, or PC+4 for JAL/JALR links. It passes through the write enable and destination register. It also keeps a registered copy of the last committed write for WB-to-ID forwarding, plus a retired-write counter.

---
 rtl/wb_stage.sv | 65 ++++++
 tb/tb_wb_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: selects register-file write data, passes through the write
// controls, and keeps a registered copy of the last write plus a write counter.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       ctrl_wb,
   input  logic [XLEN-1:0]  pc4_wb,
   input  logic [XLEN-1:0]  mem_data,
   input  logic [XLEN-1:0]  alu_data,
   input  logic [XLEN-1:0]  rd_wb,
   output logic             op_write,
   output logic [XLEN-1:0]  write_data,
   output logic [XLEN-1:0]  write_addr,
   output logic             fwd_valid,
   output logic [XLEN-1:0]  fwd_addr,
   output logic [XLEN-1:0]  fwd_data,
   output logic [CNT_W-1:0] wr_count
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } fwd_t;

   fwd_t fwd_q;

   assign op_write   = ctrl_wb[0];
   assign write_addr = rd_wb;

   // Link address wins over load data so JAL/JALR never pick up a stale load.
   always_comb begin
      write_data = alu_data;
      if (ctrl_wb[2])
         write_data = pc4_wb;
      else if (ctrl_wb[1])
         write_data = mem_data;
   end

   // x0 writes are never forwarded: their value must read back as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_q <= '0;
      end else begin
         fwd_q.valid <= op_write && (write_addr != '0);
         fwd_q.addr  <= write_addr;
         fwd_q.data  <= write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_count <= '0;
      else if (op_write)
         wr_count <= wr_count + 1'b1;
   end

   assign fwd_valid = fwd_q.valid;
   assign fwd_addr  = fwd_q.addr;
   assign fwd_data  = fwd_q.data;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a spec-level model checked on every falling
// edge, plus hand-computed literal checks; a 4-bit counter build covers wrap.
module tb_wb_stage;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      ctrl_wb = 3'b000;
   logic [XLEN-1:0] pc4_wb = '0;
   logic [XLEN-1:0] mem_data = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic [XLEN-1:0] rd_wb = '0;

   logic            op_write, fwd_valid;
   logic [XLEN-1:0] write_data, write_addr, fwd_addr, fwd_data;
   logic [31:0]     wr_count;

   logic            s_op_write, s_fwd_valid;
   logic [XLEN-1:0] s_write_data, s_write_addr, s_fwd_addr, s_fwd_data;
   logic [3:0]      s_wr_count;

   int vectors = 0;
   int miscompares = 0;

   wb_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_wb(ctrl_wb), .pc4_wb(pc4_wb),
      .mem_data(mem_data), .alu_data(alu_data), .rd_wb(rd_wb),
      .op_write(op_write), .write_data(write_data), .write_addr(write_addr),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .wr_count(wr_count)
   );

   wb_stage #(.XLEN(XLEN), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ctrl_wb(ctrl_wb), .pc4_wb(pc4_wb),
      .mem_data(mem_data), .alu_data(alu_data), .rd_wb(rd_wb),
      .op_write(s_op_write), .write_data(s_write_data), .write_addr(s_write_addr),
      .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data),
      .wr_count(s_wr_count)
   );

   always #10 clk = ~clk;

   // Model: forwarded copy of the last write and an unbounded write tally.
   logic            m_valid = 1'b0;
   logic [XLEN-1:0] m_addr = '0;
   logic [XLEN-1:0] m_data = '0;
   int unsigned     m_count = 0;

   function automatic logic [XLEN-1:0] sel_data(input logic [2:0] c,
         input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] mem, input logic [XLEN-1:0] alu);
      if (c[2]) return pc4;
      if (c[1]) return mem;
      return alu;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_addr  <= '0;
         m_data  <= '0;
         m_count <= 0;
      end else begin
         m_valid <= ctrl_wb[0] && (rd_wb != 0);
         m_addr  <= rd_wb;
         m_data  <= sel_data(ctrl_wb, pc4_wb, mem_data, alu_data);
         if (ctrl_wb[0]) m_count <= m_count + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("op_write", {31'd0, op_write}, {31'd0, ctrl_wb[0]});
      chk("write_data", write_data, sel_data(ctrl_wb, pc4_wb, mem_data, alu_data));
      chk("write_addr", write_addr, rd_wb);
      chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_valid});
      chk("fwd_addr", fwd_addr, m_addr);
      chk("fwd_data", fwd_data, m_data);
      chk("wr_count", wr_count, m_count);
      chk("wr_count4", {28'd0, s_wr_count}, {28'd0, m_count[3:0]});
      chk("fwd_valid4", {31'd0, s_fwd_valid}, {31'd0, m_valid});
   end

   task automatic reset_pulse();
      @(posedge clk); #5;
      rst_n = 1'b0;
      @(posedge clk); #5;
      rst_n = 1'b1;
   endtask

   initial begin
      int tbl [8];
      tbl = '{3, 3, 2, 2, 1, 1, 1, 1};

      #5;
      chk("reset fwd_valid", {31'd0, fwd_valid}, 32'd0);
      chk("reset fwd_addr", fwd_addr, 32'd0);
      chk("reset fwd_data", fwd_data, 32'd0);
      chk("reset wr_count", wr_count, 32'd0);
      #20 rst_n = 1'b1;

      // Combinational sweep, mid-cycle settle away from both edges
      pc4_wb = 1; mem_data = 2; alu_data = 3; rd_wb = 4;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #2;
         ctrl_wb = 3'(c);
         #10;
         chk($sformatf("mux data c=%0d", c), write_data, 32'(tbl[c]));
         chk($sformatf("mux we c=%0d", c), {31'd0, op_write}, 32'(c & 1));
         chk($sformatf("mux addr c=%0d", c), write_addr, 32'd4);
      end

      @(posedge clk); #2;
      ctrl_wb = 3'b110; mem_data = 32'hDEADBEEF; pc4_wb = 32'h104;
      #10;
      chk("priority data", write_data, 32'h104);
      chk("priority we", {31'd0, op_write}, 32'd0);

      @(posedge clk); #2;
      ctrl_wb = 3'b001; alu_data = 32'h55; rd_wb = 7;
      @(posedge clk); #1;
      chk("fwd valid", {31'd0, fwd_valid}, 32'd1);
      chk("fwd addr", fwd_addr, 32'd7);
      chk("fwd data", fwd_data, 32'h55);
      #1 rd_wb = 0;
      @(posedge clk); #1;
      chk("fwd x0 valid", {31'd0, fwd_valid}, 32'd0);

      // Async reset between edges
      #4 rst_n = 1'b0;
      #1;
      chk("async fwd_valid", {31'd0, fwd_valid}, 32'd0);
      chk("async fwd_addr", fwd_addr, 32'd0);
      chk("async fwd_data", fwd_data, 32'd0);
      chk("async wr_count", wr_count, 32'd0);
      alu_data = 32'h77;
      #1;
      chk("reset comb data", write_data, 32'h77);
      @(posedge clk); #5;
      rst_n = 1'b1;

      // Counter: 5 writes then 3 idle
      reset_pulse();
      ctrl_wb = 3'b001; rd_wb = 3;
      repeat (5) @(posedge clk);
      #2 ctrl_wb = 3'b000;
      repeat (3) @(posedge clk);
      #2;
      chk("count 5", wr_count, 32'd5);

      // 4-bit build wraps after 16 writes
      reset_pulse();
      ctrl_wb = 3'b001;
      repeat (15) @(posedge clk);
      #2;
      chk("count4 15", {28'd0, s_wr_count}, 32'd15);
      @(posedge clk); #2;
      chk("count4 wrap", {28'd0, s_wr_count}, 32'd0);
      chk("count32 16", wr_count, 32'd16);
      ctrl_wb = 3'b000;
      repeat (2) @(posedge clk);
      #2;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
